// File: rtl/hood_mode_controller.sv
// Range-hood mode controller: button-driven mode FSM with LEVEL3/SHUTDOWN countdowns,
// a one-shot LEVEL3 allowance per power session and a clean-run completion pulse.
module hood_mode_controller #(
  parameter int MODE_WIDTH   = 3,
  parameter int MAX_WIDTH    = 32,
  parameter int COUNTER_1SEC = 99_999_999,
  parameter int LEVEL3_SEC   = 60,
  parameter int SHUTDOWN_SEC = 60,
  parameter int CLEAN_SEC    = 180
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  btn_power,
  input  logic                  btn_level1,
  input  logic                  btn_level2,
  input  logic                  btn_level3,
  input  logic                  btn_clean,
  input  logic [MAX_WIDTH-1:0]  clean_running_time,
  output logic [MODE_WIDTH-1:0] current_mode,
  output logic [MAX_WIDTH-1:0]  remaining_sec,
  output logic                  level3_available,
  output logic                  clean_done
);

  typedef enum logic [MODE_WIDTH-1:0] {
    MODE_OFF      = MODE_WIDTH'(0),
    MODE_STANDBY  = MODE_WIDTH'(1),
    MODE_LEVEL1   = MODE_WIDTH'(2),
    MODE_LEVEL2   = MODE_WIDTH'(3),
    MODE_LEVEL3   = MODE_WIDTH'(4),
    MODE_CLEAN    = MODE_WIDTH'(5),
    MODE_SHUTDOWN = MODE_WIDTH'(6)
  } mode_e;

  mode_e                mode_q;
  logic [MAX_WIDTH-1:0] tick_cnt;
  logic                 tick;
  logic                 win_power;
  logic                 win_clean;
  logic                 win_level3;
  logic                 win_level2;
  logic                 win_level1;
  logic                 clean_finished;

  // Only the highest-priority pulse is ever acted on; lower ones are dropped.
  assign win_power  = btn_power;
  assign win_clean  = btn_clean  & ~btn_power;
  assign win_level3 = btn_level3 & ~btn_power & ~btn_clean;
  assign win_level2 = btn_level2 & ~btn_power & ~btn_clean & ~btn_level3;
  assign win_level1 = btn_level1 & ~btn_power & ~btn_clean & ~btn_level3 & ~btn_level2;

  assign tick           = (tick_cnt == MAX_WIDTH'(COUNTER_1SEC));
  assign clean_finished = (clean_running_time >= MAX_WIDTH'(CLEAN_SEC));
  assign current_mode   = mode_q;

  // Every branch that changes mode also restarts the one-second prescaler.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q           <= MODE_OFF;
      remaining_sec    <= '0;
      level3_available <= 1'b0;
      clean_done       <= 1'b0;
      tick_cnt         <= '0;
    end else begin
      clean_done <= 1'b0;
      tick_cnt   <= tick ? '0 : tick_cnt + MAX_WIDTH'(1);
      case (mode_q)
        MODE_OFF: begin
          if (win_power) begin
            mode_q           <= MODE_STANDBY;
            level3_available <= 1'b1;
            tick_cnt         <= '0;
          end
        end
        MODE_STANDBY, MODE_LEVEL1, MODE_LEVEL2: begin
          if (win_power) begin
            mode_q           <= MODE_OFF;
            level3_available <= 1'b0;
            tick_cnt         <= '0;
          end else if (win_clean && mode_q == MODE_STANDBY) begin
            mode_q   <= MODE_CLEAN;
            tick_cnt <= '0;
          end else if (win_level3 && level3_available) begin
            mode_q           <= MODE_LEVEL3;
            remaining_sec    <= MAX_WIDTH'(LEVEL3_SEC);
            level3_available <= 1'b0;
            tick_cnt         <= '0;
          end else if (win_level2 && mode_q != MODE_LEVEL2) begin
            mode_q   <= MODE_LEVEL2;
            tick_cnt <= '0;
          end else if (win_level1 && mode_q != MODE_LEVEL1) begin
            mode_q   <= MODE_LEVEL1;
            tick_cnt <= '0;
          end
        end
        MODE_LEVEL3: begin
          if (win_power) begin
            mode_q        <= MODE_SHUTDOWN;
            remaining_sec <= MAX_WIDTH'(SHUTDOWN_SEC);
            tick_cnt      <= '0;
          end else if (win_level2) begin
            mode_q        <= MODE_LEVEL2;
            remaining_sec <= '0;
            tick_cnt      <= '0;
          end else if (win_level1) begin
            mode_q        <= MODE_LEVEL1;
            remaining_sec <= '0;
            tick_cnt      <= '0;
          end else if (tick) begin
            if (remaining_sec <= MAX_WIDTH'(1)) begin
              mode_q        <= MODE_LEVEL2;
              remaining_sec <= '0;
              tick_cnt      <= '0;
            end else begin
              remaining_sec <= remaining_sec - MAX_WIDTH'(1);
            end
          end
        end
        MODE_SHUTDOWN: begin
          if (tick) begin
            if (remaining_sec <= MAX_WIDTH'(1)) begin
              mode_q           <= MODE_OFF;
              remaining_sec    <= '0;
              level3_available <= 1'b0;
              tick_cnt         <= '0;
            end else begin
              remaining_sec <= remaining_sec - MAX_WIDTH'(1);
            end
          end
        end
        MODE_CLEAN: begin
          if (win_power) begin
            mode_q           <= MODE_OFF;
            level3_available <= 1'b0;
            tick_cnt         <= '0;
          end else if (clean_finished) begin
            mode_q     <= MODE_STANDBY;
            clean_done <= 1'b1;
            tick_cnt   <= '0;
          end
        end
        default: begin
          mode_q           <= MODE_OFF;
          remaining_sec    <= '0;
          level3_available <= 1'b0;
          tick_cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hood_mode_controller.sv
// Directed bench for hood_mode_controller with a 4-cycle second; expected
// {mode, remaining, available, done} words are queued per step and popped at sampling.
module tb_hood_mode_controller;

  localparam int MW = 3;
  localparam int XW = 32;
  localparam int W  = MW + XW + 2;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_P    = 5'b10000;
  localparam logic [4:0] B_C    = 5'b01000;
  localparam logic [4:0] B_L3   = 5'b00100;
  localparam logic [4:0] B_L2   = 5'b00010;
  localparam logic [4:0] B_L1   = 5'b00001;

  logic          clk;
  logic          rstn;
  logic          btn_power, btn_level1, btn_level2, btn_level3, btn_clean;
  logic [XW-1:0] clean_running_time;
  logic [MW-1:0] current_mode;
  logic [XW-1:0] remaining_sec;
  logic          level3_available;
  logic          clean_done;

  logic [W-1:0]  exp_q[$];
  int            checks;
  int            errors;

  hood_mode_controller #(
    .MODE_WIDTH  (MW),
    .MAX_WIDTH   (XW),
    .COUNTER_1SEC(3),
    .LEVEL3_SEC  (2),
    .SHUTDOWN_SEC(2),
    .CLEAN_SEC   (3)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .btn_power         (btn_power),
    .btn_level1        (btn_level1),
    .btn_level2        (btn_level2),
    .btn_level3        (btn_level3),
    .btn_clean         (btn_clean),
    .clean_running_time(clean_running_time),
    .current_mode      (current_mode),
    .remaining_sec     (remaining_sec),
    .level3_available  (level3_available),
    .clean_done        (clean_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int m, input int r, input logic a, input logic d);
    exp_q.push_back({MW'(m), XW'(r), a, d});
  endtask

  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    obs = {current_mode, remaining_sec, level3_available, clean_done};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: no expected entry queued", tag);
      return;
    end
    exp_v = exp_q.pop_front();
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed mode=%0d rem=%0d avail=%0b done=%0b expected mode=%0d rem=%0d avail=%0b done=%0b",
             tag, obs[W-1 -: MW], obs[XW+1:2], obs[1], obs[0],
             exp_v[W-1 -: MW], exp_v[XW+1:2], exp_v[1], exp_v[0]);
    end
  endtask

  // Drive buttons at a falling edge, let one rising edge act, sample at the next falling edge.
  task automatic step(input logic [4:0] b, input int m, input int r, input logic a,
                      input logic d, input string tag);
    push(m, r, a, d);
    {btn_power, btn_clean, btn_level3, btn_level2, btn_level1} = b;
    @(negedge clk);
    {btn_power, btn_clean, btn_level3, btn_level2, btn_level1} = B_NONE;
    check(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    {btn_power, btn_clean, btn_level3, btn_level2, btn_level1} = B_NONE;
    clean_running_time = '0;
    @(negedge clk);
    @(negedge clk);
    push(0, 0, 1'b0, 1'b0);
    check("reset_state");
    rstn = 1'b1;

    // Power on, LEVEL3 countdown of 2 seconds, expiry to LEVEL2 after 8 cycles.
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on");
    step(B_L3, 4, 2, 1'b0, 1'b0, "l3_enter");
    for (int i = 0; i < 3; i++) step(B_NONE, 4, 2, 1'b0, 1'b0, "l3_sec2");
    for (int i = 0; i < 4; i++) step(B_NONE, 4, 1, 1'b0, 1'b0, "l3_sec1");
    step(B_NONE, 3, 0, 1'b0, 1'b0, "l3_expire");

    // LEVEL3 is spent for this session until a power cycle.
    step(B_L3, 3, 0, 1'b0, 1'b0, "l3_gated");
    step(B_P,  0, 0, 1'b0, 1'b0, "power_off");
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on2");
    step(B_L3, 4, 2, 1'b0, 1'b0, "l3_restored");

    // Power in LEVEL3 goes to SHUTDOWN; buttons there are ignored.
    step(B_P,  6, 2, 1'b0, 1'b0, "shutdown");
    step(B_NONE, 6, 2, 1'b0, 1'b0, "sd_c1");
    step(B_NONE, 6, 2, 1'b0, 1'b0, "sd_c2");
    step(B_L1, 6, 2, 1'b0, 1'b0, "sd_l1_ignored");
    step(B_NONE, 6, 1, 1'b0, 1'b0, "sd_c4");
    step(B_P,  6, 1, 1'b0, 1'b0, "sd_power_ignored");
    step(B_NONE, 6, 1, 1'b0, 1'b0, "sd_c6");
    step(B_NONE, 6, 1, 1'b0, 1'b0, "sd_c7");
    step(B_NONE, 0, 0, 1'b0, 1'b0, "sd_expire");

    // Level switching and exits from LEVEL3 by level buttons.
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on3");
    step(B_C,  5, 0, 1'b1, 1'b0, "clean_from_standby");
    step(B_L1, 5, 0, 1'b1, 1'b0, "clean_l1_ignored");
    step(B_P,  0, 0, 1'b0, 1'b0, "clean_abort");
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on4");
    step(B_L1, 2, 0, 1'b1, 1'b0, "to_l1");
    step(B_C,  2, 0, 1'b1, 1'b0, "l1_clean_ignored");
    step(B_L2, 3, 0, 1'b1, 1'b0, "to_l2");
    step(B_L3, 4, 2, 1'b0, 1'b0, "l2_to_l3");
    step(B_L1, 2, 0, 1'b0, 1'b0, "l3_to_l1");
    step(B_P,  0, 0, 1'b0, 1'b0, "power_off2");

    // Clean run completes when the elapsed time reaches 3 seconds.
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on5");
    step(B_C,  5, 0, 1'b1, 1'b0, "clean_start");
    for (int t = 0; t < 3; t++) begin
      clean_running_time = XW'(t);
      step(B_NONE, 5, 0, 1'b1, 1'b0, "clean_run");
    end
    clean_running_time = XW'(3);
    step(B_NONE, 1, 0, 1'b1, 1'b1, "clean_done_pulse");
    clean_running_time = '0;
    step(B_NONE, 1, 0, 1'b1, 1'b0, "clean_done_drop");
    step(B_C,  5, 0, 1'b1, 1'b0, "clean_start2");
    clean_running_time = XW'(1);
    step(B_P,  0, 0, 1'b0, 1'b0, "clean_abort_no_done");
    clean_running_time = '0;
    step(B_NONE, 0, 0, 1'b0, 1'b0, "off_idle");

    // Simultaneous presses resolve by priority.
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on6");
    step(B_C | B_L3, 5, 0, 1'b1, 1'b0, "prio_clean_over_l3");
    step(B_P | B_L1, 0, 0, 1'b0, 1'b0, "prio_power_in_clean");
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on7");
    step(B_P | B_L2, 0, 0, 1'b0, 1'b0, "prio_power_over_l2");
    step(B_L2, 0, 0, 1'b0, 1'b0, "off_l2_ignored");

    // A button on the expiry edge wins over the expiry.
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on8");
    step(B_L3 | B_L2, 4, 2, 1'b0, 1'b0, "prio_l3_over_l2");
    for (int i = 0; i < 3; i++) step(B_NONE, 4, 2, 1'b0, 1'b0, "l3b_sec2");
    for (int i = 0; i < 4; i++) step(B_NONE, 4, 1, 1'b0, 1'b0, "l3b_sec1");
    step(B_L1, 2, 0, 1'b0, 1'b0, "button_beats_expiry");

    // Asynchronous reset in the middle of a SHUTDOWN countdown.
    step(B_P,  0, 0, 1'b0, 1'b0, "power_off3");
    step(B_P,  1, 0, 1'b1, 1'b0, "power_on9");
    step(B_L3, 4, 2, 1'b0, 1'b0, "l3_enter3");
    step(B_P | B_L1, 6, 2, 1'b0, 1'b0, "prio_power_in_l3");
    step(B_NONE, 6, 2, 1'b0, 1'b0, "sd2_c1");
    #2;
    rstn = 1'b0;
    #1;
    push(0, 0, 1'b0, 1'b0);
    check("async_reset_now");
    @(negedge clk);
    push(0, 0, 1'b0, 1'b0);
    check("reset_held");
    rstn = 1'b1;
    step(B_P,  1, 0, 1'b1, 1'b0, "power_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hood_mode_controller.md
HOOD_MODE_CONTROLLER -- requirements
Module: hood_mode_controller

Interface
REQ-001 SHALL have parameter MODE_WIDTH, default 3, width of the mode code.
REQ-002 SHALL have parameter MAX_WIDTH, default 32, width of all time and counter values.
REQ-003 SHALL have parameter COUNTER_1SEC, default 99_999_999, last cycle count of one second (period is COUNTER_1SEC+1 cycles).
REQ-004 SHALL have parameters LEVEL3_SEC, SHUTDOWN_SEC and CLEAN_SEC, defaults 60, 60 and 180, durations in seconds.
REQ-005 SHALL have clk, input, 1, clock, rising edge.
REQ-006 SHALL have rstn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have btn_power, btn_level1, btn_level2, btn_level3 and btn_clean, input, 1 each, debounced single-cycle press pulses.
REQ-008 SHALL have clean_running_time, input, MAX_WIDTH, seconds elapsed in the current clean run, supplied by the clean-mode timer stage.
REQ-009 SHALL have current_mode, output, MODE_WIDTH, registered mode code.
REQ-010 SHALL have remaining_sec, output, MAX_WIDTH, countdown seconds in LEVEL3/SHUTDOWN, else 0.
REQ-011 SHALL have level3_available, output, 1, high when LEVEL3 may still be entered in this power session.
REQ-012 SHALL have clean_done, output, 1, one-cycle pulse when a clean run completes.

Function
REQ-013 SHALL use mode codes OFF=0, STANDBY=1, LEVEL1=2, LEVEL2=3, LEVEL3=4, CLEAN=5, SHUTDOWN=6; code 7 is unreachable and SHALL recover to OFF on the next edge.
REQ-014 SHALL resolve simultaneous button pulses with priority power > clean > level3 > level2 > level1; only the winner is acted on.
REQ-015 In OFF, btn_power SHALL go to STANDBY and set level3_available=1; all other buttons are ignored.
REQ-016 In STANDBY, btn_power→OFF; btn_clean→CLEAN; btn_level1→LEVEL1; btn_level2→LEVEL2; btn_level3→LEVEL3 only if level3_available, else ignored.
REQ-017 In LEVEL1/LEVEL2, btn_power→OFF; the level buttons switch level under the same LEVEL3 gating; btn_clean is ignored.
REQ-018 Entering LEVEL3 SHALL load remaining_sec=LEVEL3_SEC and clear level3_available in the same edge.
REQ-019 In LEVEL3, btn_level1/btn_level2→that level with remaining_sec=0; btn_power→SHUTDOWN with remaining_sec=SHUTDOWN_SEC; countdown expiry→LEVEL2.
REQ-020 In SHUTDOWN, all buttons SHALL be ignored; countdown expiry→OFF.
REQ-021 In CLEAN, btn_power→OFF without clean_done (abort); level buttons are ignored; clean_running_time>=CLEAN_SEC→STANDBY with clean_done=1 for exactly that one cycle.
REQ-022 SHALL keep an internal tick counter (MAX_WIDTH) that increments every cycle and produces a one-second tick when it equals COUNTER_1SEC, then wraps to 0; it clears to 0 on every mode change.
REQ-023 On a tick in LEVEL3/SHUTDOWN, remaining_sec SHALL decrement; when the decrement reaches 0, the expiry transition SHALL occur on that same edge, so the mode lasts exactly N*(COUNTER_1SEC+1) cycles.
REQ-024 A button transition and an expiry on the same edge SHALL give the button transition precedence.
REQ-025 remaining_sec SHALL be 0 in every mode other than LEVEL3 and SHUTDOWN.
REQ-026 Entering OFF SHALL clear level3_available.

Reset
REQ-027 While rstn=0, SHALL drive current_mode=OFF, remaining_sec=0, level3_available=0, clean_done=0 and tick counter=0, with all registers cleared asynchronously.
REQ-028 After rstn deasserts, SHALL act on button pulses from the first rising clk edge; a reset during any countdown or clean run SHALL abandon it with no clean_done.

Verification (COUNTER_1SEC=3, LEVEL3_SEC=2, SHUTDOWN_SEC=2, CLEAN_SEC=3)
REQ-029 power, level3, then idle -> mode 1, then 4 with remaining 2→1→0; mode 3 after exactly 8 cycles; level3_available=0.
REQ-030 In LEVEL2 after LEVEL3 use, btn_level3 -> ignored, mode stays 3; power, power, level3 -> mode 4 (availability restored).
REQ-031 In LEVEL3, power -> mode 6 with remaining 2; btn_level1 at cycle 3 ignored; mode 0 after 8 cycles.
REQ-032 STANDBY, clean, drive clean_running_time 0,1,2,3 -> mode 1 on the edge after the value 3 appears; clean_done high one cycle; power during CLEAN -> mode 0 with no clean_done.
REQ-033 Same-cycle power+level2 in STANDBY -> mode 0; rstn low mid-SHUTDOWN -> mode 0, remaining 0 immediately, no clk needed.
